multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_alu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative multiply/divide.
// Multiply uses one shift/add step per cycle and divide uses one restoring
// shift/subtract step per cycle; both run WIDTH steps on operand magnitudes
// and apply the sign correction when the result is written.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH - 1);

  state_t           state_reg;
  logic [SHW:0]     cnt_reg;
  logic [2:0]       iop_reg;      // low bits of the iterative op code
  logic             neg_reg;      // negate the magnitude result at the end
  logic             divz_reg;     // divisor was zero
  logic [WIDTH-1:0] hi_reg;       // partial product high half / remainder
  logic [WIDTH-1:0] lo_reg;       // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0] opnd_reg;     // multiplicand / divisor magnitude
  logic             out_valid_reg;
  logic             zero_reg;
  logic [WIDTH-1:0] result_reg;

  logic             accept;
  logic             is_iter;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] load_lo;
  logic [WIDTH-1:0] load_opnd;
  logic             load_neg;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] iter_result;

  // Never busy and accepting at once: only IDLE, or DONE being drained.
  assign in_ready  = (state_reg == IDLE) || (state_reg == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_iter   = (op[4:3] == 2'b10);
  assign shamt     = b[SHW-1:0];
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;

  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // Single-cycle operation decode; unknown codes yield zero.
  always_comb begin
    alu_result = '0;
    case (op)
      5'h00:   alu_result = a + b;
      5'h01:   alu_result = a - b;
      5'h02:   alu_result = a & b;
      5'h03:   alu_result = a | b;
      5'h04:   alu_result = a << shamt;
      5'h05:   alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      5'h06:   alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
      5'h07:   alu_result = a ^ b;
      5'h08:   alu_result = a >> shamt;
      5'h09:   alu_result = $signed(a) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  // Operand magnitudes and final sign for the iterative datapath.
  always_comb begin
    load_lo   = b;
    load_opnd = a;
    load_neg  = 1'b0;
    case (op[2:0])
      3'd1: begin load_lo = abs_b; load_opnd = abs_a; load_neg = a[WIDTH-1] ^ b[WIDTH-1]; end
      3'd2: begin load_lo = b;     load_opnd = abs_a; load_neg = a[WIDTH-1]; end
      3'd4: begin load_lo = abs_a; load_opnd = abs_b; load_neg = a[WIDTH-1] ^ b[WIDTH-1]; end
      3'd5: begin load_lo = a;     load_opnd = b; end
      3'd6: begin load_lo = abs_a; load_opnd = abs_b; load_neg = a[WIDTH-1]; end
      3'd7: begin load_lo = a;     load_opnd = b; end
      default: begin load_lo = b;  load_opnd = a; end
    endcase
  end

  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd_reg});

  // One shift/add (multiply) or restoring shift/subtract (divide) step.
  always_comb begin
    if (iop_reg[2]) begin
      hi_next = div_ok ? (div_shift[WIDTH-1:0] - opnd_reg) : div_shift[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], div_ok};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  assign prod_fix = neg_reg ? -{hi_next, lo_next} : {hi_next, lo_next};
  assign q_fix    = neg_reg ? -lo_next : lo_next;
  assign r_fix    = neg_reg ? -hi_next : hi_next;

  // Select the final iterative result from the last step's values.
  always_comb begin
    iter_result = '0;
    case (iop_reg)
      3'd0:       iter_result = prod_fix[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:       iter_result = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5: iter_result = divz_reg ? '1 : q_fix;
      default:    iter_result = r_fix;
    endcase
  end

  // Control FSM with registered result, flag and valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      iop_reg       <= '0;
      neg_reg       <= 1'b0;
      divz_reg      <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      opnd_reg      <= '0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (is_iter) begin
              state_reg     <= BUSY;
              out_valid_reg <= 1'b0;
              cnt_reg       <= '0;
              iop_reg       <= op[2:0];
              neg_reg       <= load_neg;
              divz_reg      <= (b == '0);
              hi_reg        <= '0;
              lo_reg        <= load_lo;
              opnd_reg      <= load_opnd;
            end else begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              result_reg    <= alu_result;
              zero_reg      <= (alu_result == '0);
            end
          end else if (state_reg == DONE && out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        BUSY: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            result_reg    <= iter_result;
            zero_reg      <= (iter_result == '0);
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed table,
// handshake/reset sequences and randomized ops against an arithmetic model.
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  typedef struct {
    string        name;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [4:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] r, input logic z,
                              input int l);
    vec_t v;
    v.name = n; v.op = o; v.a = x; v.b = y; v.res = r; v.z = z; v.lat = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic on 64-bit values.
  function automatic logic [W-1:0] model(input logic [4:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [63:0] p;
    longint      sx;
    longint      sy;
    logic [4:0]  sh;
    sh = y[4:0];
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      5'h00: return x + y;
      5'h01: return x - y;
      5'h02: return x & y;
      5'h03: return x | y;
      5'h04: return x << sh;
      5'h05: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'h06: return (x < y) ? 32'd1 : 32'd0;
      5'h07: return x ^ y;
      5'h08: return x >> sh;
      5'h09: return $signed(x) >>> sh;
      5'h10: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      5'h11: begin p = sx * sy; return p[63:32]; end
      5'h12: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      5'h13: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      5'h14: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = sx / sy; return p[31:0];
      end
      5'h15: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'h16: begin
        if (y == 0) return x;
        p = sx % sy; return p[31:0];
      end
      5'h17: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] o);
    return (o >= 5'h10 && o <= 5'h17) ? W + 1 : 1;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Present an op at a falling edge, let it be accepted, then scramble inputs.
  task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 5'($urandom);
  endtask

  // Cycles from acceptance until out_valid, sampled at falling edges.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat;
    logic   seen;
    logic [W-1:0] exp_r;
    logic [4:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", {31'b0, zero}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Directed vector table.
    vecs.push_back(mk("ADD",      5'h00, 32'd5,          32'd7,          32'd12,         1'b0, 1));
    vecs.push_back(mk("SUB",      5'h01, 32'd5,          32'd5,          32'd0,          1'b1, 1));
    vecs.push_back(mk("SLL",      5'h04, 32'd1,          32'h21,         32'd2,          1'b0, 1));
    vecs.push_back(mk("SRA",      5'h09, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  1'b0, 1));
    vecs.push_back(mk("SRL",      5'h08, 32'h8000_0000,  32'h3F,         32'd1,          1'b0, 1));
    vecs.push_back(mk("SLT",      5'h05, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1));
    vecs.push_back(mk("SLTU",     5'h06, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1));
    vecs.push_back(mk("XOR",      5'h07, 32'hF0F0_F0F0,  32'hFFFF_0000,  32'h0F0F_F0F0,  1'b0, 1));
    vecs.push_back(mk("AND",      5'h02, 32'hF0F0_F0F0,  32'hFFFF_0000,  32'hF0F0_0000,  1'b0, 1));
    vecs.push_back(mk("OR",       5'h03, 32'h0F,         32'hF0,         32'hFF,         1'b0, 1));
    vecs.push_back(mk("MULHU",    5'h13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 33));
    vecs.push_back(mk("MUL",      5'h10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 33));
    vecs.push_back(mk("MULH",     5'h11, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0, 33));
    vecs.push_back(mk("MULHSU",   5'h12, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 33));
    vecs.push_back(mk("DIV",      5'h14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 33));
    vecs.push_back(mk("REM",      5'h16, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 33));
    vecs.push_back(mk("DIVU_z",   5'h15, 32'd7,          32'd0,          32'hFFFF_FFFF,  1'b0, 33));
    vecs.push_back(mk("REMU_z",   5'h17, 32'd7,          32'd0,          32'd7,          1'b0, 33));
    vecs.push_back(mk("DIV_z",    5'h14, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1'b0, 33));
    vecs.push_back(mk("REM_z",    5'h16, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b0, 33));
    vecs.push_back(mk("DIV_ovf",  5'h14, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 33));
    vecs.push_back(mk("REM_ovf",  5'h16, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, 33));
    vecs.push_back(mk("ILL_0A",   5'h0A, 32'd5,          32'd7,          32'd0,          1'b1, 1));
    vecs.push_back(mk("ILL_1F",   5'h1F, 32'd5,          32'd7,          32'd0,          1'b1, 1));

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check({vecs[i].name, "_result"}, result, vecs[i].res);
      check({vecs[i].name, "_zero"}, {31'b0, zero}, {31'b0, vecs[i].z});
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      $display("[TB] %s op=%h a=%h b=%h -> result=%h zero=%b lat=%0d",
               vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, result, zero, lat);
      consume();
    end

    // Back-pressure: result held while out_ready is low, then overlapped accept.
    issue(5'h00, 32'd3, 32'd4);
    wait_valid(lat);
    check("hold_latency", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", result, 32'd7);
      check("hold_zero", {31'b0, zero}, 32'd0);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    $display("[TB] hold: result=%h held 5 cycles", result);
    out_ready = 1'b1; op = 5'h00; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    #1;
    check("overlap_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("overlap_out_valid", {31'b0, out_valid}, 32'd1);
    check("overlap_result", result, 32'd2);
    $display("[TB] overlap accept: result=%h out_valid=%b", result, out_valid);
    @(negedge clk);
    out_ready = 1'b0;
    check("overlap_drained", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a divide.
    issue(5'h14, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_late_result", {31'b0, seen}, 32'd0);
    $display("[TB] reset abort: late_result=%b", seen);

    // Randomized ops against the model.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0)
        ro = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(10, 15)) : 5'($urandom_range(24, 31));
      else if ($urandom_range(0, 1) == 0)
        ro = 5'($urandom_range(0, 9));
      else
        ro = 5'($urandom_range(16, 23));
      ra = pick_operand();
      rb = pick_operand();
      exp_r = model(ro, ra, rb);
      issue(ro, ra, rb);
      wait_valid(lat);
      check("rand_result", result, exp_r);
      check("rand_zero", {31'b0, zero}, {31'b0, (exp_r == 0)});
      check("rand_latency", 32'(lat), 32'(model_lat(ro)));
      $display("[TB] rand op=%h a=%h b=%h -> result=%h exp=%h lat=%0d",
               ro, ra, rb, result, exp_r, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
